// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch-stage PC generator with a small circular return-address stack
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int unsigned             XLEN         = 32,
  parameter logic [XLEN-1:0]         RESET_VECTOR = '0,
  parameter int unsigned             STEP         = 4,
  parameter int unsigned             RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             halt,
  input  logic                             redirect_valid,
  input  logic [XLEN-1:0]                  redirect_pc,
  input  logic                             trap_valid,
  input  logic [XLEN-1:0]                  trap_vector,
  input  logic                             call_push,
  input  logic                             ret_pop,
  output logic [XLEN-1:0]                  currPC,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic [XLEN-1:0]                  ras_top
);

  localparam int unsigned C_PW = $clog2(RAS_DEPTH);
  localparam int unsigned C_CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] currpc_q, currpc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [C_PW-1:0] wptr_q, wptr_d;
  logic [C_CW-1:0] count_q, count_d;

  logic [XLEN-1:0] seq_pc;
  logic [C_PW-1:0] top_idx;
  logic [C_PW-1:0] wptr_inc;
  logic [XLEN-1:0] top_val;
  logic            ras_empty;
  logic            advance;

  // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
  always_comb begin
    seq_pc    = currpc_q + XLEN'(STEP);
    ras_empty = (count_q == '0);
    advance   = !trap_valid && !redirect_valid && !halt;
    top_idx   = (wptr_q == '0) ? C_PW'(RAS_DEPTH - 1) : wptr_q - C_PW'(1);
    wptr_inc  = (wptr_q == C_PW'(RAS_DEPTH - 1)) ? '0 : wptr_q + C_PW'(1);
    top_val   = ras_q[top_idx];
  end

  always_comb begin
    currpc_d = seq_pc;
    if (trap_valid)
      currpc_d = {trap_vector[XLEN-1:2], 2'b00};
    else if (redirect_valid)
      currpc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (halt)
      currpc_d = currpc_q;
    else if (ret_pop && !ras_empty)
      currpc_d = top_val;
  end

  always_comb begin
    ras_d   = ras_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (trap_valid) begin
      count_d = '0;
    end else if (advance) begin
      if (call_push && ret_pop && !ras_empty) begin
        // Tail-call style: consume the top and replace it in one step.
        ras_d[top_idx] = seq_pc;
      end else if (call_push) begin
        ras_d[wptr_q] = seq_pc;
        wptr_d        = wptr_inc;
        if (count_q != C_CW'(RAS_DEPTH))
          count_d = count_q + C_CW'(1);
      end else if (ret_pop && !ras_empty) begin
        wptr_d  = top_idx;
        count_d = count_q - C_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      currpc_q <= RESET_VECTOR;
      wptr_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++)
        ras_q[i] <= '0;
    end else begin
      currpc_q <= currpc_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      ras_q    <= ras_d;
    end
  end

  assign currPC    = currpc_q;
  assign ras_count = count_q;
  assign ras_top   = ras_empty ? '0 : top_val;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Directed self-checking bench for pc_gen (default parameters)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt, redirect_valid, trap_valid, call_push, ret_pop;
  logic [31:0] redirect_pc, trap_vector;
  logic [31:0] currPC, ras_top;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .call_push      (call_push),
    .ret_pop        (ret_pop),
    .currPC         (currPC),
    .ras_count      (ras_count),
    .ras_top        (ras_top)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    halt = 0; redirect_valid = 0; trap_valid = 0; call_push = 0; ret_pop = 0;
  endtask

  task automatic redir(input logic [31:0] pc);
    idle();
    redirect_valid = 1; redirect_pc = pc;
    step();
    redirect_valid = 0;
  endtask

  task automatic expect3(input string tag, input logic [31:0] pc,
                         input logic [31:0] cnt, input logic [31:0] top);
    chk({tag, ".pc"},  currPC, pc);
    chk({tag, ".cnt"}, {29'd0, ras_count}, cnt);
    chk({tag, ".top"}, ras_top, top);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pops [5];
    logic [31:0] cnts [5];
    pops = '{32'h14, 32'h10, 32'hC, 32'h8, 32'hC};
    cnts = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};

    idle();
    redirect_pc = '0; trap_vector = '0;
    reset_n = 0;
    #3;
    expect3("reset", 32'h0, 0, 0);

    @(negedge clk);
    reset_n = 1;
    chk("seq0", currPC, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("seq%0d", i), currPC, 32'(4 * i));
    end
    chk("seq.cnt", {29'd0, ras_count}, 0);

    redir(32'h100);
    chk("redir100", currPC, 32'h100);
    trap_valid = 1; trap_vector = 32'h200;
    redirect_valid = 1; redirect_pc = 32'h300; halt = 1;
    step();
    expect3("prio.trap", 32'h200, 0, 0);
    trap_valid = 0;
    step();
    chk("prio.redir", currPC, 32'h300);
    idle(); halt = 1;
    for (int i = 0; i < 3; i++) step();
    chk("halt.hold", currPC, 32'h300);

    redir(32'h100);
    call_push = 1;
    step();
    expect3("push", 32'h104, 1, 32'h104);
    redir(32'h400);
    expect3("redir400", 32'h400, 1, 32'h104);
    step(); step();
    chk("adv408", currPC, 32'h408);
    ret_pop = 1;
    step();
    expect3("pop", 32'h104, 0, 0);
    step();
    expect3("pop.empty", 32'h108, 0, 0);

    redir(32'h0);
    call_push = 1;
    for (int i = 0; i < 5; i++) step();
    expect3("ovf", 32'h14, 4, 32'h14);
    call_push = 0; ret_pop = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("ovfpop%0d.pc", i), currPC, pops[i]);
      chk($sformatf("ovfpop%0d.cnt", i), {29'd0, ras_count}, cnts[i]);
    end

    redir(32'h500);
    call_push = 1;
    step();
    ret_pop = 1;
    step();
    expect3("pushpop", 32'h504, 1, 32'h508);
    call_push = 0;
    step();
    expect3("pop508", 32'h508, 0, 0);
    call_push = 1;
    step();
    expect3("pushpop.empty", 32'h50C, 1, 32'h50C);
    halt = 1;
    step();
    expect3("halt.ras", 32'h50C, 1, 32'h50C);
    idle();
    trap_valid = 1; trap_vector = 32'h603;
    step();
    expect3("trap.flush", 32'h600, 0, 0);

    redir(32'hFFFF_FFFC);
    chk("wrap.pre", currPC, 32'hFFFF_FFFC);
    idle();
    step();
    chk("wrap", currPC, 32'h0);
    redir(32'h123);
    chk("align", currPC, 32'h120);

    call_push = 1;
    for (int i = 0; i < 3; i++) step();
    expect3("pre.areset", 32'h12C, 3, 32'h12C);
    idle(); halt = 1;
    step();
    #2;
    reset_n = 0;
    #1;
    expect3("areset", 32'h0, 0, 0);
    @(negedge clk);
    reset_n = 1; idle();
    step();
    expect3("post.reset", 32'h4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
